// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_multi_ch_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, level debounce and press pulse.
module btn_debounce #(
  parameter int DBNC_CNT_MAX = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_stable,
  output logic btn_press
);

  localparam int CW = $clog2(DBNC_CNT_MAX + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      cnt        <= '0;
      btn_stable <= 1'b0;
      btn_press  <= 1'b0;
    end else begin
      sync_p0   <= btn_raw;
      sync_p1   <= sync_p0;
      btn_press <= 1'b0;
      if (sync_p1 != btn_stable) begin
        if (cnt == CW'(DBNC_CNT_MAX - 1)) begin
          btn_stable <= sync_p1;
          btn_press  <= sync_p1;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// NUM_CH PWM outputs from one shared carrier, edge- or centre-aligned, with
// button-driven, double-buffered duty control applied at period boundaries.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int DBNC_CNT_MAX = 1000,
  parameter int DUTY_STEP    = 16,
  parameter int DUTY_RST     = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      incr_duty,
  input  logic                      decr_duty,
  input  logic                      ch_sel,
  input  logic                      center_mode,
  output logic [NUM_CH-1:0]         PWM_OUT,
  output logic [$clog2(NUM_CH)-1:0] sel_ch,
  output logic [CNT_W-1:0]          DUTY_CYCLE,
  output logic                      period_start
);

  localparam int SEL_W = $clog2(NUM_CH);

  typedef logic [CNT_W-1:0] duty_t;

  localparam duty_t MAX  = duty_t'(cnt_max(CNT_W));
  localparam duty_t DRST = duty_t'(DUTY_RST);

  function automatic duty_t sat_incr(input duty_t d);
    logic [CNT_W:0] s;
    s = {1'b0, d} + (CNT_W + 1)'(DUTY_STEP);
    return (s > {1'b0, MAX}) ? MAX : s[CNT_W-1:0];
  endfunction

  function automatic duty_t sat_decr(input duty_t d);
    logic [CNT_W:0] s;
    s = {1'b0, d} - (CNT_W + 1)'(DUTY_STEP);
    return s[CNT_W] ? '0 : s[CNT_W-1:0];
  endfunction

  logic [2:0] btn_level_unused;
  logic       incr_press;
  logic       decr_press;
  logic       sel_press;

  btn_debounce #(.DBNC_CNT_MAX(DBNC_CNT_MAX)) u_dbnc_incr (
    .clk(clk), .rst(rst), .btn_raw(incr_duty),
    .btn_stable(btn_level_unused[0]), .btn_press(incr_press)
  );

  btn_debounce #(.DBNC_CNT_MAX(DBNC_CNT_MAX)) u_dbnc_decr (
    .clk(clk), .rst(rst), .btn_raw(decr_duty),
    .btn_stable(btn_level_unused[1]), .btn_press(decr_press)
  );

  btn_debounce #(.DBNC_CNT_MAX(DBNC_CNT_MAX)) u_dbnc_sel (
    .clk(clk), .rst(rst), .btn_raw(ch_sel),
    .btn_stable(btn_level_unused[2]), .btn_press(sel_press)
  );

  duty_t     duty_req [NUM_CH];
  duty_t     duty_act [NUM_CH];
  duty_t     cnt;
  duty_t     cnt_nxt;
  logic      dir_down;
  logic      dir_nxt;
  pwm_mode_e mode_act;
  pwm_mode_e mode_nxt;
  logic      bnd;

  // Shadow duty registers and channel selection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_ch <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_req[i] <= DRST;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (SEL_W'(i) == sel_ch && (incr_press ^ decr_press))
          duty_req[i] <= incr_press ? sat_incr(duty_req[i]) : sat_decr(duty_req[i]);
      end
      if (sel_press)
        sel_ch <= (sel_ch == SEL_W'(NUM_CH - 1)) ? '0 : sel_ch + 1'b1;
    end
  end

  assign DUTY_CYCLE = duty_req[sel_ch];

  // Carrier: a boundary is cnt==0 while counting up, in either mode
  assign bnd = (cnt == '0) && !dir_down;

  always_comb begin
    cnt_nxt  = cnt + 1'b1;
    dir_nxt  = dir_down;
    mode_nxt = mode_act;
    if (bnd) begin
      mode_nxt = center_mode ? PWM_CENTER : PWM_EDGE;
    end else if (mode_act == PWM_CENTER) begin
      if (dir_down) begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == duty_t'(1)) dir_nxt = 1'b0;
      end else if (cnt == MAX) begin
        cnt_nxt = MAX - 1'b1;
        dir_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      dir_down     <= 1'b0;
      mode_act     <= PWM_EDGE;
      period_start <= 1'b0;
      PWM_OUT      <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= DRST;
    end else begin
      cnt          <= cnt_nxt;
      dir_down     <= dir_nxt;
      mode_act     <= mode_nxt;
      period_start <= (cnt_nxt == '0) && !dir_nxt;
      // The boundary cycle already compares against the new duty so the
      // whole new period is uniform.
      for (int i = 0; i < NUM_CH; i++) begin
        if (bnd) duty_act[i] <= duty_req[i];
        PWM_OUT[i] <= cnt < (bnd ? duty_req[i] : duty_act[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: press table plus period/duty measurements.
module tb_pwm_multi_ch;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int DBNC   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              incr_duty = 1'b0;
  logic              decr_duty = 1'b0;
  logic              ch_sel = 1'b0;
  logic              center_mode = 1'b0;
  logic [NUM_CH-1:0] PWM_OUT;
  logic [1:0]        sel_ch;
  logic [CNT_W-1:0]  DUTY_CYCLE;
  logic              period_start;

  pwm_multi_ch #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DBNC_CNT_MAX(DBNC),
    .DUTY_STEP(16), .DUTY_RST(128)
  ) dut (
    .clk(clk), .rst(rst), .incr_duty(incr_duty), .decr_duty(decr_duty),
    .ch_sel(ch_sel), .center_mode(center_mode), .PWM_OUT(PWM_OUT),
    .sel_ch(sel_ch), .DUTY_CYCLE(DUTY_CYCLE), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int per_n;
  int hi [NUM_CH];
  int mixed;

  typedef struct {
    logic [2:0] code;
    int         exp_duty;
    int         exp_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic [2:0] code, input int d, input int s);
    vec_t v;
    v.code = code;
    v.exp_duty = d;
    v.exp_sel = s;
    vecs.push_back(v);
  endfunction

  // code bits: {ch_sel, decr_duty, incr_duty}
  task automatic press(input logic [2:0] code, input int hold);
    {ch_sel, decr_duty, incr_duty} = code;
    repeat (hold) @(posedge clk);
    #1;
    {ch_sel, decr_duty, incr_duty} = 3'b000;
    repeat (DBNC + 6) @(posedge clk);
    #1;
  endtask

  task automatic wait_ps();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!period_start && t < 700);
    check("period_start_seen", int'(period_start), 1);
  endtask

  // Starts on the negedge where period_start was seen; ends on the next one.
  task automatic measure();
    per_n = 0;
    mixed = 0;
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    do begin
      @(negedge clk);
      per_n++;
      for (int i = 0; i < NUM_CH; i++) hi[i] += int'(PWM_OUT[i]);
      if (PWM_OUT != '0 && PWM_OUT != '1) mixed++;
    end while (!period_start && per_n < 1200);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", int'(PWM_OUT), 0);
    check("rst_sel", int'(sel_ch), 0);
    check("rst_duty", int'(DUTY_CYCLE), 128);
    check("rst_ps", int'(period_start), 0);
    rst = 1'b0;

    // Default edge-mode periods
    wait_ps();
    measure();
    check("t1_period", per_n, 256);
    for (int i = 0; i < NUM_CH; i++) check($sformatf("t1_hi%0d", i), hi[i], 128);
    check("t1_inphase", mixed, 0);

    // Short glitch is rejected
    @(posedge clk);
    #1;
    incr_duty = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    incr_duty = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t2_glitch", int'(DUTY_CYCLE), 128);

    // Accepted press mid-period: shadow changes, active duty waits for boundary
    wait_ps();
    fork
      measure();
      begin
        @(posedge clk);
        #1;
        incr_duty = 1'b1;
        repeat (18) @(posedge clk);
        #1;
        check("t2_lat18", int'(DUTY_CYCLE), 128);
        @(posedge clk);
        #1;
        check("t2_lat19", int'(DUTY_CYCLE), 144);
        repeat (11) @(posedge clk);
        #1;
        incr_duty = 1'b0;
      end
    join
    check("t2_old_hi0", hi[0], 128);
    measure();
    check("t2_period", per_n, 256);
    check("t2_new_hi0", hi[0], 144);
    for (int i = 1; i < NUM_CH; i++) check($sformatf("t2_hi%0d", i), hi[i], 128);

    // Press table: saturation, channel select, simultaneous presses
    add(3'b001, 160, 0); add(3'b001, 176, 0); add(3'b001, 192, 0); add(3'b001, 208, 0);
    add(3'b001, 224, 0); add(3'b001, 240, 0); add(3'b001, 255, 0); add(3'b001, 255, 0);
    add(3'b010, 239, 0); add(3'b010, 223, 0); add(3'b010, 207, 0); add(3'b010, 191, 0);
    add(3'b010, 175, 0); add(3'b010, 159, 0); add(3'b010, 143, 0); add(3'b010, 127, 0);
    add(3'b010, 111, 0); add(3'b010,  95, 0); add(3'b010,  79, 0); add(3'b010,  63, 0);
    add(3'b010,  47, 0); add(3'b010,  31, 0); add(3'b010,  15, 0); add(3'b010,   0, 0);
    add(3'b010,   0, 0);
    add(3'b100, 128, 1); add(3'b100, 128, 2); add(3'b100, 128, 3); add(3'b100, 0, 0);
    add(3'b100, 128, 1); add(3'b100, 128, 2); add(3'b001, 144, 2);
    add(3'b101, 128, 3); add(3'b100,   0, 0); add(3'b100, 128, 1); add(3'b100, 160, 2);
    add(3'b011, 160, 2);
    foreach (vecs[k]) begin
      press(vecs[k].code, 20);
      check($sformatf("vec%0d_duty", k), int'(DUTY_CYCLE), vecs[k].exp_duty);
      check($sformatf("vec%0d_sel", k), int'(sel_ch), vecs[k].exp_sel);
    end

    wait_ps();
    measure();
    check("t4_period", per_n, 256);
    check("t4_hi0", hi[0], 0);
    check("t4_hi1", hi[1], 128);
    check("t4_hi2", hi[2], 160);
    check("t4_hi3", hi[3], 128);

    // Centre mode requested mid-period takes effect at the next boundary
    fork
      measure();
      begin
        repeat (50) @(posedge clk);
        #1;
        center_mode = 1'b1;
      end
    join
    check("t5_still_edge", per_n, 256);
    check("t5_still_hi2", hi[2], 160);
    measure();
    check("t5_c_period", per_n, 510);
    check("t5_c_hi0", hi[0], 0);
    check("t5_c_hi1", hi[1], 255);
    check("t5_c_hi2", hi[2], 319);
    check("t5_c_hi3", hi[3], 255);
    fork
      measure();
      begin
        repeat (50) @(posedge clk);
        #1;
        center_mode = 1'b0;
      end
    join
    check("t5_still_center", per_n, 510);
    measure();
    check("t5_e_period", per_n, 256);
    check("t5_e_hi1", hi[1], 128);

    // Asynchronous reset mid-period
    repeat (100) @(posedge clk);
    #2;
    check("t6_pre_pwm", int'(PWM_OUT), 4'b1110);
    check("t6_pre_sel", int'(sel_ch), 2);
    rst = 1'b1;
    #1;
    check("t6_rst_pwm", int'(PWM_OUT), 0);
    check("t6_rst_sel", int'(sel_ch), 0);
    check("t6_rst_duty", int'(DUTY_CYCLE), 128);
    check("t6_rst_ps", int'(period_start), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ps();
    measure();
    check("t6_period", per_n, 256);
    for (int i = 0; i < NUM_CH; i++) check($sformatf("t6_hi%0d", i), hi[i], 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
